// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared core constants and the fetch buffer entry type.
//   XLEN, INSTR_BYTES, RESET_PC_DEFAULT, NOP encoding, fetch_entry_t {pc, instr, filled}
package fetch_unit_pkg;
    localparam int XLEN = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_2000;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            filled;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: fetch stage signal bundle.
//   redirect_valid/redirect_pc/stall  : from execute
//   imem_req_*                        : request channel to instruction memory
//   imem_resp_*                       : in-order response channel from memory
//   if_valid/if_instruction/if_pc     : fetched instruction to execute
//   master = fetch unit side, slave = environment side
interface fetch_unit_if;
    import fetch_unit_pkg::*;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            stall;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            if_valid;
    logic [XLEN-1:0] if_instruction;
    logic [XLEN-1:0] if_pc;
    modport master (
        input  redirect_valid, redirect_pc, stall, imem_req_ready, imem_resp_valid, imem_resp_data,
        output imem_req_valid, imem_req_addr, if_valid, if_instruction, if_pc
    );
    modport slave (
        output redirect_valid, redirect_pc, stall, imem_req_ready, imem_resp_valid, imem_resp_data,
        input  imem_req_valid, imem_req_addr, if_valid, if_instruction, if_pc
    );
endinterface

// File: rtl/fetch_unit_buffer.sv
// fetch_buffer: circular fetch buffer with alloc/fill/read pointers and filled flags.
//   clk, rst      : clock, async active-high reset
//   clear         : drop every entry and rewind all pointers
//   alloc/alloc_pc: reserve the entry at alloc_ptr for a newly issued request
//   fill/fill_data: write the oldest unfilled entry (ignored when none is unfilled)
//   consume       : retire the head entry
//   count         : allocated entries, unfilled: allocated but not yet filled
//   head          : entry at read_ptr
module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter int              DEPTH    = 2,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    localparam int             CW       = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            alloc,
    input  logic [XLEN-1:0] alloc_pc,
    input  logic            fill,
    input  logic [XLEN-1:0] fill_data,
    input  logic            consume,
    output logic [CW-1:0]   count,
    output logic [CW-1:0]   unfilled,
    output fetch_entry_t    head
);
    localparam int PW = $clog2(DEPTH);
    // Idle entries hold RESET_PC/0 so the output bus reads the reset values when empty
    localparam fetch_entry_t EMPTY = '{pc: RESET_PC, instr: '0, filled: 1'b0};
    fetch_entry_t    ent [DEPTH];
    logic [PW-1:0]   alloc_ptr, fill_ptr, read_ptr;
    logic            fill_ok;
    assign fill_ok = fill && unfilled != '0;
    assign head = ent[read_ptr];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= EMPTY;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            read_ptr  <= '0;
            count     <= '0;
            unfilled  <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= EMPTY;
            alloc_ptr <= '0;
            fill_ptr  <= '0;
            read_ptr  <= '0;
            count     <= '0;
            unfilled  <= '0;
        end else begin
            // alloc, fill and consume always target distinct entries
            if (alloc) begin
                ent[alloc_ptr] <= '{pc: alloc_pc, instr: '0, filled: 1'b0};
                alloc_ptr      <= alloc_ptr + PW'(1);
            end
            if (fill_ok) begin
                ent[fill_ptr].instr  <= fill_data;
                ent[fill_ptr].filled <= 1'b1;
                fill_ptr             <= fill_ptr + PW'(1);
            end
            if (consume) begin
                ent[read_ptr] <= EMPTY;
                read_ptr      <= read_ptr + PW'(1);
            end
            count    <= count + CW'(alloc) - CW'(consume);
            unfilled <= unfilled + CW'(alloc) - CW'(fill_ok);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end; owns the PC, issues imem requests, buffers
// responses and squashes wrong-path fetches on redirect.
//   clk, rst : clock, async active-high reset
//   bus      : fetch_unit_if.master (redirect/stall in, imem request/response, if_* out)
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int              DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    logic [XLEN-1:0] pc;
    logic [CW-1:0]   count, unfilled, drop_cnt, drop_sum, drop_next;
    logic            redirect, resp, fire, fill, consume;
    fetch_entry_t    head;
    assign redirect = bus.redirect_valid;
    assign resp = bus.imem_resp_valid;
    // No issue while wrong-path responses are still due, so drop_cnt + unfilled <= DEPTH
    assign bus.imem_req_valid = !rst && count < CW'(DEPTH) && drop_cnt == '0 && !redirect;
    assign bus.imem_req_addr = pc;
    assign fire = bus.imem_req_valid && bus.imem_req_ready;
    assign fill = resp && drop_cnt == '0 && !redirect;
    assign bus.if_valid = head.filled && !redirect;
    assign bus.if_instruction = head.instr;
    assign bus.if_pc = head.pc;
    assign consume = bus.if_valid && !bus.stall;
    // On redirect every unfilled entry becomes a response to discard; one arriving now is eaten at once
    assign drop_sum = drop_cnt + unfilled;
    assign drop_next = redirect ? drop_sum - CW'(resp && drop_sum != '0)
                                : drop_cnt - CW'(resp && drop_cnt != '0);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            drop_cnt <= '0;
        end else begin
            pc       <= redirect ? bus.redirect_pc & ~XLEN'(INSTR_BYTES - 1)
                      : fire     ? pc + XLEN'(INSTR_BYTES) : pc;
            drop_cnt <= drop_next;
        end
    end
    fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect),
        .alloc     (fire),
        .alloc_pc  (pc),
        .fill      (fill),
        .fill_data (bus.imem_resp_data),
        .consume   (consume),
        .count     (count),
        .unfilled  (unfilled),
        .head      (head)
    );
endmodule
